pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
Parametrised pipeline stage register, successor to the fixed MEM/WB latch. It carries a control field, a data payload and a destination register number between any two pipeline stages. Transfer uses a valid/ready handshake with a 2-entry skid buffer, so stalls and back-pressure never drop or duplicate an instruction. It adds a flush that inserts a bubble and a saturating counter of back-pressure cycles for the IO/debug bus.

Parameters:
CTRL_W, 2, width of control bundle (e.g. {wreg, m2reg}); every bit is a write-enable-class signal that must be 0 in a bubble
DATA_W, 64, payload width (e.g. {mo, alu})
RN_W, 5, destination register number width
CNT_W, 16, width of the back-pressure counter

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream payload
in_rn  in  RN_W  upstream destination register
out_valid  out  1  downstream presented instruction is valid
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control bundle; all zero whenever out_valid=0
out_data  out  DATA_W  payload
out_rn  out  RN_W  destination register
flush  in  1  discard all held instructions
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock is clock. Reset is resetn: asynchronous, active-low. During reset, all state and outputs clear: out_valid=0, out_ctrl=0, out_data=0, out_rn=0, stall_cnt=0, skid entry empty and zeroed, in_ready=1 one cycle after deassertion.
- Storage: main register (drives outputs) plus one skid register. All outputs are registered. in_ready = NOT skid_valid, driven from a flop with no combinational path from out_ready.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Main empty, or main emitting this cycle: an accepted word loads main directly; a non-empty skid loads main first, and an accepted word then goes to skid only if skid was not the source.
- Main full, not emitting, word accepted: the word goes to skid; in_ready drops next cycle.
- Skid full and main emits: skid moves to main, skid empties, in_ready rises next cycle.
- Ordering is strictly FIFO. Zero-bubble throughput when out_ready is held at 1; latency is 1 cycle (accept at edge N, visible after edge N).
- Bubble rule: when out_valid=0, out_ctrl=0 (registered zero, not gated), so a bubble can never write the register file or memory. out_data and out_rn hold their last values when no load occurs.
- flush=1: at the next edge, main and skid are invalidated and their ctrl fields are zeroed. An input accepted in the same cycle is discarded, so flush has priority over accept. in_ready=1 on the following cycle.
- stall_cnt: increments by 1 on each edge where out_valid && !out_ready && !flush, and saturates at 2^CNT_W-1 with no wrap. cnt_clr sets it to 0 and has priority over increment. It is unaffected by flush.
- Reset mid-operation: contents are lost immediately (asynchronous); no partial transfer is completed.
- X-safety: payload fields of an invalid in_valid are never loaded into a valid slot.

Decomposition:
- Shared package pipe_pkg: default widths (RN_W=5, word width 32) and named control-bundle bit positions (WREG, M2REG), so that all pipeline stages agree.
- Natural sub-module: sat_counter (CNT_W, inc, clr, value), reused by other IO performance counters. The skid logic stays inline.

Test Plan:
- Reset: hold resetn=0 with in_valid=1 and random data, then release -> out_valid=0, out_ctrl=0, stall_cnt=0; in_ready=1 on the first edge after release.
- Streaming: out_ready=1, push 8 words with data=i and rn=i, ctrl=2'b11 -> outputs appear 1 cycle later in order 0..7 with no gap; in_ready stays 1.
- Back-pressure: push A, B, C with out_ready=0 -> A held in main, B in skid, in_ready=0, C held upstream and not lost; raise out_ready -> A, B, C emitted in order; stall_cnt equals the number of stalled cycles (e.g. 4).
- Flush with full skid and a simultaneous in_valid=1 (word D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D never appears at the output.
- Counter saturation with CNT_W=3: hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt=7; assert cnt_clr together with a stall -> stall_cnt=0.
- Async reset asserted mid-stall with both entries full -> outputs zero immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Widths and control-bundle bit positions shared by every pipeline stage.
package pipe_pkg;
    localparam int RN_W_DEF   = 5;
    localparam int WORD_W     = 32;
    localparam int CTRL_W_DEF = 2;
    // Control bundle layout: {wreg, m2reg}
    localparam int WREG       = 1;
    localparam int M2REG      = 0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);
    logic [CNT_W-1:0] value_reg;
    logic [CNT_W-1:0] value_next;

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (inc && (value_reg != {CNT_W{1'b1}})) begin
            value_next = value_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// bubble-inserting flush and a saturating back-pressure counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 2 * WORD_W,
    parameter int RN_W   = RN_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RN_W-1:0]   in_rn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RN_W-1:0]   out_rn,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              main_valid_reg, main_valid_next;
    logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg,  main_data_next;
    logic [RN_W-1:0]   main_rn_reg,    main_rn_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [RN_W-1:0]   skid_rn_reg,    skid_rn_next;
    logic              in_ready_reg;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready_reg;
    assign emit   = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_ctrl_next  = main_ctrl_reg;
        main_data_next  = main_data_reg;
        main_rn_next    = main_rn_reg;
        skid_valid_next = skid_valid_reg;
        skid_ctrl_next  = skid_ctrl_reg;
        skid_data_next  = skid_data_reg;
        skid_rn_next    = skid_rn_reg;

        if (flush) begin
            // Payload is kept; only valid and the write-enable-class ctrl are killed.
            main_valid_next = 1'b0;
            main_ctrl_next  = '0;
            skid_valid_next = 1'b0;
            skid_ctrl_next  = '0;
        end else if (!main_valid_reg || emit) begin
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_ctrl_next  = skid_ctrl_reg;
                main_data_next  = skid_data_reg;
                main_rn_next    = skid_rn_reg;
                if (accept) begin
                    skid_ctrl_next = in_ctrl;
                    skid_data_next = in_data;
                    skid_rn_next   = in_rn;
                end else begin
                    skid_valid_next = 1'b0;
                    skid_ctrl_next  = '0;
                end
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_ctrl_next  = in_ctrl;
                main_data_next  = in_data;
                main_rn_next    = in_rn;
            end else begin
                main_valid_next = 1'b0;
                main_ctrl_next  = '0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_ctrl_next  = in_ctrl;
            skid_data_next  = in_data;
            skid_rn_next    = in_rn;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            main_valid_reg <= 1'b0;
            main_ctrl_reg  <= '0;
            main_data_reg  <= '0;
            main_rn_reg    <= '0;
            skid_valid_reg <= 1'b0;
            skid_ctrl_reg  <= '0;
            skid_data_reg  <= '0;
            skid_rn_reg    <= '0;
            in_ready_reg   <= 1'b0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_ctrl_reg  <= main_ctrl_next;
            main_data_reg  <= main_data_next;
            main_rn_reg    <= main_rn_next;
            skid_valid_reg <= skid_valid_next;
            skid_ctrl_reg  <= skid_ctrl_next;
            skid_data_reg  <= skid_data_next;
            skid_rn_reg    <= skid_rn_next;
            // Registered so out_ready never reaches in_ready combinationally.
            in_ready_reg   <= !skid_valid_next;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (main_valid_reg && !out_ready && !flush),
        .clr    (cnt_clr),
        .value  (stall_cnt)
    );

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;
    assign out_rn    = main_rn_reg;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, back-pressure, flush,
// counter saturation and asynchronous reset mid-stall.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int CTRL_W = 2;
    localparam int DATA_W = 64;
    localparam int RN_W   = 5;
    localparam int CNT_W  = 3;

    logic              clock = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [RN_W-1:0]   in_rn;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [RN_W-1:0]   out_rn;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [CTRL_W-1:0] CTRL_ALL = CTRL_W'((1 << WREG) | (1 << M2REG));

    pipe_skid_stage #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RN_W   (RN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_rn     (in_rn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .out_rn    (out_rn),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_cnt++;
        if (observed !== expected) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [RN_W-1:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_rn    = r;
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        drive(1'b1, 2'b11, {$urandom, $urandom}, 5'($urandom));

        // Reset held with garbage input
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        resetn = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        chk("rel_out_ctrl", 64'(out_ctrl), 64'd0);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, CTRL_ALL, 64'(i), 5'(i));
            step();
            chk($sformatf("strm_valid_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("strm_data_%0d", i), out_data, 64'(i));
            chk($sformatf("strm_rn_%0d", i), 64'(out_rn), 64'(i));
            chk($sformatf("strm_ready_%0d", i), 64'(in_ready), 64'd1);
        end
        drive(1'b0, 2'b11, 64'hDEAD, 5'd31);
        step();
        chk("strm_end_valid", 64'(out_valid), 64'd0);
        chk("strm_end_ctrl", 64'(out_ctrl), 64'd0);
        chk("strm_end_data_hold", out_data, 64'd7);
        chk("strm_stall_cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure: A in main, B in skid, C waits upstream
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 64'hAAAA, 5'd10);
        step();
        chk("bp_a_data", out_data, 64'hAAAA);
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 2'b10, 64'hBBBB, 5'd11);
        step();
        chk("bp_b_ready", 64'(in_ready), 64'd0);
        chk("bp_b_main_a", out_data, 64'hAAAA);
        drive(1'b1, 2'b11, 64'hCCCC, 5'd12);
        step();
        step();
        chk("bp_c_held_main", out_data, 64'hAAAA);
        chk("bp_c_ready", 64'(in_ready), 64'd0);
        chk("bp_stall_3", 64'(stall_cnt), 64'd3);
        step();
        chk("bp_stall_4", 64'(stall_cnt), 64'd4);
        out_ready = 1'b1;
        step();
        chk("bp_out_b_data", out_data, 64'hBBBB);
        chk("bp_out_b_ctrl", 64'(out_ctrl), 64'd2);
        chk("bp_out_b_ready", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 2'b00, 64'h0, 5'd0);
        chk("bp_out_c_data", out_data, 64'hCCCC);
        chk("bp_out_c_rn", 64'(out_rn), 64'd12);
        step();
        chk("bp_drain_valid", 64'(out_valid), 64'd0);
        chk("bp_stall_final", 64'(stall_cnt), 64'd4);

        // Flush with both entries full and word D offered
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 64'hEEEE, 5'd14);
        step();
        drive(1'b1, 2'b11, 64'hFFFF, 5'd15);
        step();
        chk("fl_full_ready", 64'(in_ready), 64'd0);
        chk("fl_pre_stall", 64'(stall_cnt), 64'd5);
        drive(1'b1, 2'b11, 64'hD0D0, 5'd13);
        flush = 1'b1;
        step();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_stall_kept", 64'(stall_cnt), 64'd5);
        // Flush beats an accept while in_ready is high
        step();
        chk("fl_accept_discard", 64'(out_valid), 64'd0);
        flush = 1'b0;
        drive(1'b0, 2'b00, 64'h0, 5'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_no_d_valid", 64'(out_valid), 64'd0);
        chk("fl_no_d_ctrl", 64'(out_ctrl), 64'd0);

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("sat_cleared", 64'(stall_cnt), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 64'h6666, 5'd6);
        step();
        drive(1'b0, 2'b00, 64'h0, 5'd0);
        for (int i = 0; i < 10; i++) step();
        chk("sat_value", 64'(stall_cnt), 64'd7);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("sat_clr_prio", 64'(stall_cnt), 64'd0);
        step();
        chk("sat_after_clr", 64'(stall_cnt), 64'd1);

        // Asynchronous reset with both entries full
        drive(1'b1, 2'b11, 64'h7777, 5'd7);
        step();
        drive(1'b0, 2'b00, 64'h0, 5'd0);
        chk("ar_skid_full", 64'(in_ready), 64'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("ar_out_data", out_data, 64'd0);
        chk("ar_out_rn", 64'(out_rn), 64'd0);
        chk("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        resetn = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("ar_post_valid", 64'(out_valid), 64'd0);
        chk("ar_post_ready", 64'(in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
